// File: rtl/lcd_bus_sequencer.sv
// HD44780 character-LCD transfer engine behind a Nios II multi-cycle custom instruction.
// Runs the power-up delay and init sequence, then one timed byte write per start.
module lcd_bus_sequencer #(
  parameter int unsigned POWERUP_CYC    = 32'd750000,
  parameter int unsigned SETUP_CYC      = 32'd2,
  parameter int unsigned EN_CYC         = 32'd12,
  parameter int unsigned SHORT_WAIT_CYC = 32'd2000,
  parameter int unsigned LONG_WAIT_CYC  = 32'd82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        init_done,
  output logic        lcd_enable,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
  localparam int unsigned MAX_B   = (SHORT_WAIT_CYC > EN_CYC) ? SHORT_WAIT_CYC : EN_CYC;
  localparam int unsigned MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int          CW      = $clog2(MAX_CYC + 32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_IDLE  = 3'd4
  } state_t;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0E;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_init_idx;
  logic          r_init_done;
  logic          r_is_cpu;
  logic [8:0]    r_cur;
  logic          r_pend;
  logic [8:0]    r_pend_data;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_done;
  logic [7:0]    r_result;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_init_idx_nxt;
  logic          w_init_done_nxt;
  logic          w_is_cpu_nxt;
  logic [8:0]    w_cur_nxt;
  logic          w_pend_nxt;
  logic [8:0]    w_pend_data_nxt;
  logic          w_en_nxt;
  logic          w_rs_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_done_nxt;
  logic [7:0]    w_result_nxt;
  logic [CW-1:0] w_len;
  logic          w_last;
  logic          w_long;
  logic          w_capture;
  logic          w_unused;

  // Clear and return-home are the only commands with the long execution time.
  assign w_long    = ~r_cur[8] && (r_cur[7:2] == 6'd0) && (r_cur[7:0] != 8'd0);
  assign w_capture = ~r_init_done && start && ~r_pend;
  assign w_last    = (r_cnt == (w_len - CNT_ONE));
  assign w_unused  = ^{datab, dataa[31:9]};

  // Duration of the current timed state.
  always_comb begin
    w_len = CNT_ONE;
    case (r_state)
      ST_PWRUP: w_len = CW'(POWERUP_CYC);
      ST_SETUP: w_len = CW'(SETUP_CYC);
      ST_PULSE: w_len = CW'(EN_CYC);
      ST_WAIT:  w_len = w_long ? CW'(LONG_WAIT_CYC) : CW'(SHORT_WAIT_CYC);
      default:  w_len = CNT_ONE;
    endcase
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_ONE;
    w_init_idx_nxt  = r_init_idx;
    w_init_done_nxt = r_init_done;
    w_is_cpu_nxt    = r_is_cpu;
    w_cur_nxt       = r_cur;
    w_pend_nxt      = r_pend | w_capture;
    w_pend_data_nxt = w_capture ? dataa[8:0] : r_pend_data;
    w_done_nxt      = 1'b0;
    w_result_nxt    = r_result;
    case (r_state)
      ST_PWRUP: begin
        if (w_last) begin
          w_state_nxt    = ST_SETUP;
          w_cnt_nxt      = CNT_ZERO;
          w_init_idx_nxt = 2'd0;
          w_is_cpu_nxt   = 1'b0;
          w_cur_nxt      = {1'b0, init_byte(2'd0)};
        end else begin
          w_state_nxt = ST_PWRUP;
        end
      end
      ST_SETUP: begin
        if (w_last) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (w_last) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_PULSE;
        end
      end
      ST_WAIT: begin
        if (w_last) begin
          w_cnt_nxt = CNT_ZERO;
          if (r_is_cpu) begin
            w_state_nxt  = ST_IDLE;
            w_done_nxt   = 1'b1;
            w_result_nxt = r_cur[7:0];
          end else if (r_init_idx == 2'd3) begin
            w_state_nxt     = ST_IDLE;
            w_init_done_nxt = 1'b1;
          end else begin
            w_state_nxt    = ST_SETUP;
            w_init_idx_nxt = r_init_idx + 2'd1;
            w_cur_nxt      = {1'b0, init_byte(r_init_idx + 2'd1)};
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (r_pend) begin
          w_state_nxt  = ST_SETUP;
          w_cur_nxt    = r_pend_data;
          w_pend_nxt   = 1'b0;
          w_is_cpu_nxt = 1'b1;
        end else if (start) begin
          w_state_nxt  = ST_SETUP;
          w_cur_nxt    = dataa[8:0];
          w_is_cpu_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_PWRUP;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase

    w_en_nxt = (w_state_nxt == ST_PULSE);
    if ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_WAIT)) begin
      w_rs_nxt   = w_cur_nxt[8];
      w_data_nxt = w_cur_nxt[7:0];
    end else begin
      w_rs_nxt   = r_rs;
      w_data_nxt = r_data;
    end
  end

  // State register; clk_en low freezes everything, reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_PWRUP;
      r_cnt       <= CNT_ZERO;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_is_cpu    <= 1'b0;
      r_cur       <= 9'd0;
      r_pend      <= 1'b0;
      r_pend_data <= 9'd0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_done      <= 1'b0;
      r_result    <= 8'h00;
    end else if (clk_en) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_init_done <= w_init_done_nxt;
      r_is_cpu    <= w_is_cpu_nxt;
      r_cur       <= w_cur_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_en        <= w_en_nxt;
      r_rs        <= w_rs_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_result    <= w_result_nxt;
    end
  end

  assign lcd_enable = r_en;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = r_data;
  assign done       = r_done;
  assign init_done  = r_init_done;
  assign result     = {24'h000000, r_result};

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: E-pulse and done scoreboards, a vector
// table of CPU writes, and hand-written power-up, pending, freeze and reset sequences.
module tb_lcd_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'h0;
  logic [31:0] datab = 32'h0;
  logic [31:0] result;
  logic        done;
  logic        init_done;
  logic        lcd_enable;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_bus_sequencer #(
    .POWERUP_CYC    (32'd20),
    .SETUP_CYC      (32'd2),
    .EN_CYC         (32'd4),
    .SHORT_WAIT_CYC (32'd10),
    .LONG_WAIT_CYC  (32'd50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .start      (start),
    .dataa      (dataa),
    .datab      (datab),
    .result     (result),
    .done       (done),
    .init_done  (init_done),
    .lcd_enable (lcd_enable),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data)
  );

  typedef struct { logic rs; logic [7:0] byte_v; int rise; int en_w; int tot_w; } ev_t;
  typedef struct { int cyc; logic [31:0] res; } dn_t;
  typedef struct { logic [31:0] dataa; logic rs; logic [7:0] byte_v; int lat; } vec_t;

  ev_t ev_q[$];
  dn_t dn_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  acyc = 0;
  int  done_seen = 0;
  int  exp_init_cyc = 124;
  bit  mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, acyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    acyc++;
  endtask

  task automatic drive_start(input logic [31:0] d);
    start = 1'b1;
    dataa = d;
    datab = $urandom();
    tick();
    start = 1'b0;
  endtask

  task automatic push_init();
    ev_q.push_back('{1'b0, 8'h38, 22, 4, 4});
    ev_q.push_back('{1'b0, 8'h0E, 38, 4, 4});
    ev_q.push_back('{1'b0, 8'h06, 54, 4, 4});
    ev_q.push_back('{1'b0, 8'h01, 70, 4, 4});
  endtask

  task automatic run_until_done(input int limit);
    int d0;
    int n;
    d0 = done_seen;
    n = 0;
    while ((done_seen == d0) && (n < limit)) begin
      tick();
      n++;
    end
    chk("done_within_budget", 32'(done_seen != d0), 32'd1);
  endtask

  // Monitor: E pulses and done pulses are matched against the queued expectations.
  ev_t        cur_ev;
  int         en_w = 0;
  int         tot_w = 0;
  bit         in_pulse = 1'b0;
  logic       prev_en = 1'b0;
  logic       prev_init = 1'b0;
  logic [7:0] prev_data = 8'h00;
  dn_t        d_ev;
  always @(negedge clk) begin
    if (mon_on) begin
      if (lcd_enable && !prev_en) begin
        chk("e_pulse_expected", 32'(ev_q.size() != 0), 32'd1);
        if (ev_q.size() != 0) begin
          cur_ev = ev_q.pop_front();
          chk("e_rise_cycle", acyc, cur_ev.rise);
          chk("e_rs", 32'(lcd_rs), 32'(cur_ev.rs));
          chk("e_data", 32'(lcd_data), 32'(cur_ev.byte_v));
          chk("setup_data", 32'(prev_data), 32'(cur_ev.byte_v));
          chk("lcd_rw", 32'(lcd_rw), 32'd0);
          in_pulse = 1'b1;
          en_w = 0;
          tot_w = 0;
        end
      end
      if (lcd_enable && in_pulse) begin
        tot_w++;
        if (clk_en) en_w++;
      end
      if (!lcd_enable && prev_en && in_pulse) begin
        chk("e_width_enabled", en_w, cur_ev.en_w);
        chk("e_width_total", tot_w, cur_ev.tot_w);
        in_pulse = 1'b0;
      end
      if (done) begin
        done_seen++;
        chk("done_expected", 32'(dn_q.size() != 0), 32'd1);
        if (dn_q.size() != 0) begin
          d_ev = dn_q.pop_front();
          chk("done_cycle", acyc, d_ev.cyc);
          chk("result", result, d_ev.res);
        end
      end
      if (init_done && !prev_init) chk("init_done_cycle", acyc, exp_init_cyc);
      prev_en   = lcd_enable;
      prev_init = init_done;
      prev_data = lcd_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   k;
    int   n;
    vecs[0] = '{32'h0000_0141, 1'b1, 8'h41, 17};
    vecs[1] = '{32'h0000_0001, 1'b0, 8'h01, 57};
    vecs[2] = '{32'h0000_0002, 1'b0, 8'h02, 57};
    vecs[3] = '{32'h0000_0004, 1'b0, 8'h04, 17};
    vecs[4] = '{32'h0000_0003, 1'b0, 8'h03, 57};
    vecs[5] = '{32'h0000_0000, 1'b0, 8'h00, 17};
    vecs[6] = '{32'hFFFF_FE01, 1'b0, 8'h01, 57};
    vecs[7] = '{32'h0000_0101, 1'b1, 8'h01, 17};
    vecs[8] = '{32'h0000_0080, 1'b0, 8'h80, 17};

    repeat (3) @(posedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_enable", 32'(lcd_enable), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_rw", 32'(lcd_rw), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_result", result, 32'd0);

    // Power-up with an early start held pending and a second early start ignored.
    @(posedge clk);
    #1;
    reset = 1'b0;
    acyc = 0;
    push_init();
    repeat (5) tick();
    ev_q.push_back('{1'b1, 8'h48, 127, 4, 4});
    dn_q.push_back('{141, 32'h0000_0048});
    drive_start(32'h0000_E148);
    repeat (2) tick();
    drive_start(32'h0000_0155);
    run_until_done(400);
    chk("init_done_high", 32'(init_done), 32'd1);

    // Table of CPU writes, each followed by an ignored start mid-transfer.
    for (int i = 0; i < 9; i++) begin
      tick();
      tick();
      k = acyc;
      ev_q.push_back('{vecs[i].rs, vecs[i].byte_v, k + 3, 4, 4});
      dn_q.push_back('{k + vecs[i].lat, {24'h000000, vecs[i].byte_v}});
      drive_start(vecs[i].dataa);
      repeat (3) tick();
      drive_start(~vecs[i].dataa);
      run_until_done(100);
    end

    // clk_en freeze of 7 cycles in the middle of PULSE.
    tick();
    tick();
    k = acyc;
    ev_q.push_back('{1'b1, 8'h5A, k + 3, 4, 11});
    dn_q.push_back('{k + 24, 32'h0000_005A});
    drive_start(32'h0000_015A);
    repeat (3) tick();
    clk_en = 1'b0;
    repeat (7) tick();
    clk_en = 1'b1;
    run_until_done(100);

    // Reset (with a coincident start) during PULSE aborts the transfer.
    tick();
    tick();
    k = acyc;
    ev_q.push_back('{1'b1, 8'h33, k + 3, 2, 2});
    drive_start(32'h0000_0133);
    repeat (3) tick();
    reset = 1'b1;
    start = 1'b1;
    dataa = 32'h0000_01AA;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    acyc = 0;
    chk("abort_enable", 32'(lcd_enable), 32'd0);
    chk("abort_data", 32'(lcd_data), 32'd0);
    chk("abort_init_done", 32'(init_done), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    push_init();
    n = 0;
    while (!init_done && (n < 300)) begin
      tick();
      n++;
    end
    chk("reinit_done", 32'(init_done), 32'd1);

    tick();
    k = acyc;
    ev_q.push_back('{1'b1, 8'h6B, k + 3, 4, 4});
    dn_q.push_back('{k + 17, 32'h0000_006B});
    drive_start(32'h0000_016B);
    run_until_done(100);

    repeat (5) tick();
    chk("e_queue_drained", ev_q.size(), 32'd0);
    chk("done_queue_drained", dn_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Timed transfer engine for the HD44780-style character LCD, exposed as a Nios II multi-cycle custom instruction.
- Out of reset it runs the power-up delay and then the fixed 4-command init sequence.
- After init it executes one command or data byte per custom-instruction `start`, asserting `done` only after the LCD execution time has elapsed.
- It is the only driver of the LCD pins and sequences both the init traffic and the CPU traffic onto them.

Parameters:
- POWERUP_CYC, 750000: wait after reset before the first init command (15 ms at 50 MHz).
- SETUP_CYC, 2: cycles RS/data are stable before `lcd_enable` rises.
- EN_CYC, 12: `lcd_enable` high width in cycles (240 ns).
- SHORT_WAIT_CYC, 2000: execution wait for normal commands and data writes (40 us).
- LONG_WAIT_CYC, 82000: execution wait for clear/home (1.64 ms).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  custom-instruction clock enable; low freezes all state.
- start  in  1  custom-instruction start, one-cycle pulse.
- dataa  in  32  [7:0] = byte, [8] = RS (0 command, 1 data), [31:9] ignored.
- datab  in  32  unused, ignored.
- result  out  32  {24'b0, last byte issued by a CPU transfer}.
- done  out  1  one-cycle completion pulse for a CPU transfer.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- lcd_enable  out  1  LCD E strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD R/W; always 0 (write-only).
- lcd_data  out  8  LCD data bus.

Behaviour:
- Reset: already decided — one clock; reset is synchronous and active-high, on ports `clk` and `reset`.
  - Reset state: FSM = PWRUP, all counters = 0, pending flag = 0.
  - Output reset values: `lcd_enable`, `lcd_rs`, `lcd_rw` = 0; `lcd_data` = 0x00; `done` = 0; `init_done` = 0; `result` = 0.
  - Reset asserted mid-transfer aborts it immediately: E drops and no `done` is issued.
- `clk_en` = 0: FSM, counters and pending flag hold; outputs hold their current values; `start` is ignored.
- Cycle numbering below counts only cycles with `clk_en` = 1.
- FSM states: PWRUP, SETUP, PULSE, WAIT, IDLE.
- PWRUP: counts POWERUP_CYC cycles, then loads init index 0 and enters SETUP.
- Init sequence bytes, all with RS = 0, issued back-to-back with no gap: 0x38, 0x0E, 0x06, 0x01.
- SETUP (SETUP_CYC cycles):
  - `lcd_rs`/`lcd_data` are driven with the current byte; `lcd_enable` = 0.
- PULSE (EN_CYC cycles): `lcd_enable` = 1; RS and data held.
- WAIT:
  - `lcd_enable` = 0; RS and data held.
  - Lasts LONG_WAIT_CYC if RS = 0 and byte[7:2] == 0 and byte != 0 (clear 0x01, home 0x02/0x03); otherwise SHORT_WAIT_CYC.
- End of WAIT:
  - During init: advance the init index; after the 4th command go to IDLE and set `init_done` in the next cycle.
  - During a CPU transfer: go to IDLE; `done` = 1 for exactly the following cycle; `result` updates in that same cycle.
- IDLE with `start` = 1 (or pending = 1): latch `dataa[8:0]`, clear pending, and enter SETUP in the next cycle.
- CPU latency: `start` in cycle 0 gives SETUP in cycles 1..S, PULSE for the next E cycles, WAIT for the next W cycles, and `done` in cycle S+E+W+1.
- `start` before `init_done`:
  - `dataa[8:0]` is captured into a single pending slot.
  - The transfer is executed starting the cycle init completes; `done` follows normally.
- `start` while a CPU transfer is in progress or already pending: ignored (protocol violation; no `done` is generated for it).
- `start` coincident with reset: reset wins.

Test Plan:
All scenarios use POWERUP_CYC=20, SETUP_CYC=2, EN_CYC=4, SHORT_WAIT_CYC=10, LONG_WAIT_CYC=50; cycle 0 = first cycle with reset low.
- Power-up: release reset, no `start` -> `lcd_enable` pulses 4 times (4 cycles each) carrying bytes 0x38, 0x0E, 0x06, 0x01 with RS=0 and RW=0 throughout; first E rises at cycle 22; `init_done` rises at cycle 124.
- Data write: after init, `start` with `dataa`=0x141 -> RS=1, data=0x41, E high for 4 cycles; `done` pulses exactly 17 cycles after `start`; `result`=0x00000041.
- Long command: `start` with `dataa`=0x001 -> RS=0, WAIT lasts 50 cycles; `done` 57 cycles after `start`. With `dataa`=0x002 -> `done` also at 57. With `dataa`=0x004 -> `done` at 17.
- Early start: `start` with `dataa`=0x148 at cycle 5 -> byte held pending; its E rises at cycle 127; `done` at cycle 141; no second `done`.
- `clk_en` freeze: drop `clk_en` for 7 cycles mid-PULSE -> E stays high throughout the freeze; the total E width counted in enabled cycles remains 4; `done` is delayed by exactly 7 cycles.
- Reset mid-transfer: assert reset during a PULSE -> next cycle E=0, data=0x00, `init_done`=0, no `done` pulse; the init sequence restarts after release.
